// File: rtl/instr_mem_arbiter.sv
// Arbitrates the single-port instruction RAM between CPU fetch and host/debug masters.
// Optional write protection of the low program region: define IMEM_ARB_WRITE_PROT_EN.
module instr_mem_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int MAX_FETCH_RUN = 8,
    parameter int PROT_TOP      = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_read,
    input  logic [ADDR_W-1:0] f_address,
    output logic              f_waitrequest,
    output logic [DATA_W-1:0] f_readdata,
    output logic              f_readdatavalid,
    input  logic              h_read,
    input  logic              h_write,
    input  logic [ADDR_W-1:0] h_address,
    input  logic [3:0]        h_byteenable,
    input  logic [DATA_W-1:0] h_writedata,
    output logic              h_waitrequest,
    output logic [DATA_W-1:0] h_readdata,
    output logic              h_readdatavalid,
    input  logic              h_stall_req,
    output logic              h_stall_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken,
    output logic              wr_error
);

    if (MAX_FETCH_RUN < 1 || MAX_FETCH_RUN > 255 || PROT_TOP < 0 || PROT_TOP > (1 << ADDR_W)) begin : g_param_check
        $error("instr_mem_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SHARED,
        ST_DRAIN,
        ST_EXCL
    } state_e;

    localparam logic [7:0] RUN_LIMIT = 8'(MAX_FETCH_RUN);

    state_e     state_q;
    logic [7:0] run_q, run_d;
    logic       f_rvalid_q, h_rvalid_q, ack_q;
    logic       h_req, f_elig, gnt_f, gnt_h, wr_drop;

    assign h_req  = h_read | h_write;
    assign f_elig = f_read & (state_q == ST_SHARED);

    always_comb begin
        gnt_f = 1'b0;
        gnt_h = 1'b0;
        if (f_elig && h_req) begin
            if (run_q < RUN_LIMIT) gnt_f = 1'b1;
            else                   gnt_h = 1'b1;
        end else begin
            gnt_f = f_elig;
            gnt_h = h_req;
        end
    end

    // Only contested fetch wins extend the run; an unopposed fetch leaves it alone.
    always_comb begin
        run_d = run_q;
        if (gnt_h)                                 run_d = '0;
        else if (gnt_f && h_req && run_q != 8'hFF) run_d = run_q + 8'd1;
    end

`ifdef IMEM_ARB_WRITE_PROT_EN
    localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W+1)'(PROT_TOP);
    logic werr_q;

    // Dropped writes still complete the handshake so the host never stalls on them.
    assign wr_drop = gnt_h & h_write & (state_q != ST_EXCL) & ({1'b0, h_address} < PROT_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) werr_q <= 1'b0;
        else          werr_q <= wr_drop;
    end
    assign wr_error = werr_q;
`else
    assign wr_drop  = 1'b0;
    assign wr_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SHARED;
            run_q      <= '0;
            f_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            run_q      <= run_d;
            f_rvalid_q <= gnt_f;
            h_rvalid_q <= gnt_h & h_read;
            case (state_q)
                ST_SHARED: begin
                    if (h_stall_req) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!h_stall_req) begin
                        state_q <= ST_SHARED;
                    end else if (!gnt_f) begin
                        state_q <= ST_EXCL;
                        ack_q   <= 1'b1;
                    end
                end
                ST_EXCL: begin
                    if (!h_stall_req) begin
                        state_q <= ST_SHARED;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_SHARED;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign f_waitrequest   = f_read & ~gnt_f;
    assign h_waitrequest   = h_req & ~gnt_h;
    assign mem_chipselect  = (gnt_f | gnt_h) & ~wr_drop;
    assign mem_write       = gnt_h & h_write & ~wr_drop;
    assign mem_address     = gnt_f ? f_address : h_address;
    assign mem_byteenable  = gnt_f ? 4'hF : h_byteenable;
    assign mem_writedata   = h_writedata;
    assign mem_clken       = 1'b1;
    assign f_readdata      = mem_readdata;
    assign h_readdata      = mem_readdata;
    assign f_readdatavalid = f_rvalid_q;
    assign h_readdatavalid = h_rvalid_q;
    assign h_stall_ack     = ack_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: vector table, directed corner sequences, random traffic vs a reference model.
module tb_instr_mem_arbiter;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int MAXRUN = 8;
    localparam int PROT   = 256;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          f_read, f_waitrequest, f_readdatavalid;
    logic [AW-1:0] f_address;
    logic [DW-1:0] f_readdata;
    logic          h_read, h_write, h_waitrequest, h_readdatavalid, h_stall_req, h_stall_ack;
    logic [AW-1:0] h_address;
    logic [3:0]    h_byteenable;
    logic [DW-1:0] h_writedata, h_readdata;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken, wr_error;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata = '0;

    always #5 clk = ~clk;

    instr_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_FETCH_RUN(MAXRUN), .PROT_TOP(PROT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .f_read(f_read), .f_address(f_address), .f_waitrequest(f_waitrequest),
        .f_readdata(f_readdata), .f_readdatavalid(f_readdatavalid),
        .h_read(h_read), .h_write(h_write), .h_address(h_address),
        .h_byteenable(h_byteenable), .h_writedata(h_writedata),
        .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
        .h_readdatavalid(h_readdatavalid),
        .h_stall_req(h_stall_req), .h_stall_ack(h_stall_ack),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_clken(mem_clken), .wr_error(wr_error)
    );

    function automatic logic [31:0] init_word(input int a);
        return (a == 16) ? 32'hDEADBEEF : 32'hCAFE0000 + 32'(a);
    endfunction

    // RAM: registered read, byte-enabled write, loaded on the first clock edge
    logic [31:0] ram [0:1023];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model: ownership mode, fetch run length, memory image, next-cycle returns
    logic [31:0] shadow [0:1023];
    int          m_mode;   // 0 shared, 1 draining, 2 exclusive
    int          m_run;
    logic        e_fv, e_hv, e_ack, e_werr;
    logic [31:0] e_fd, e_hd;

    logic        s_fwait, s_hwait, s_cs, s_we, s_fv, s_hv, s_ack, s_werr;
    logic [31:0] s_fd, s_hd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle();
        logic fwin, hwin, hreq, drop;
        int   nxt;
        #1;
        hreq = h_read | h_write;
        fwin = f_read && (m_mode == 0) && !(hreq && m_run >= MAXRUN);
        hwin = hreq && !fwin;
        drop = 1'b0;
`ifdef IMEM_ARB_WRITE_PROT_EN
        drop = hwin && h_write && (int'(h_address) < PROT) && (m_mode != 2);
`endif
        s_fwait = f_waitrequest; s_hwait = h_waitrequest;
        s_cs = mem_chipselect;   s_we = mem_write;
        chkb("f_waitrequest", s_fwait, f_read && !fwin);
        chkb("h_waitrequest", s_hwait, hreq && !hwin);
        chkb("mem_chipselect", s_cs, (fwin || hwin) && !drop);
        chkb("mem_write", s_we, hwin && h_write && !drop);
        chkb("mem_clken", mem_clken, 1'b1);
        if (fwin) begin
            chk("mem_address(f)", 32'(mem_address), 32'(f_address));
            chk("mem_byteenable(f)", 32'(mem_byteenable), 32'hF);
        end else if (hwin && !drop) begin
            chk("mem_address(h)", 32'(mem_address), 32'(h_address));
            chk("mem_byteenable(h)", 32'(mem_byteenable), 32'(h_byteenable));
            if (h_write) chk("mem_writedata", mem_writedata, h_writedata);
        end
        e_fv = fwin;           e_fd = shadow[f_address];
        e_hv = hwin && h_read; e_hd = shadow[h_address];
        e_werr = drop;
        if (hwin && h_write && !drop)
            for (int b = 0; b < 4; b++)
                if (h_byteenable[b]) shadow[h_address][8*b +: 8] = h_writedata[8*b +: 8];
        if (hwin) m_run = 0;
        else if (fwin && hreq && m_run < 255) m_run++;
        case (m_mode)
            0:       nxt = h_stall_req ? 1 : 0;
            default: nxt = h_stall_req ? 2 : 0;
        endcase
        m_mode = nxt;
        e_ack  = (nxt == 2);
        @(posedge clk);
        #1;
        s_fv = f_readdatavalid; s_fd = f_readdata;
        s_hv = h_readdatavalid; s_hd = h_readdata;
        s_ack = h_stall_ack;    s_werr = wr_error;
        chkb("f_readdatavalid", s_fv, e_fv);
        chkb("h_readdatavalid", s_hv, e_hv);
        chkb("h_stall_ack", s_ack, e_ack);
        chkb("wr_error", s_werr, e_werr);
        if (e_fv) chk("f_readdata", s_fd, e_fd);
        if (e_hv) chk("h_readdata", s_hd, e_hd);
    endtask

    task automatic idle_inputs();
        f_read = 1'b0; f_address = '0;
        h_read = 1'b0; h_write = 1'b0; h_address = '0;
        h_byteenable = '0; h_writedata = '0; h_stall_req = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0;
        e_fv = 1'b0; e_hv = 1'b0; e_ack = 1'b0; e_werr = 1'b0;
        s_fwait = 1'b0; s_hwait = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chkb("reset f_readdatavalid", f_readdatavalid, 1'b0);
        chkb("reset h_readdatavalid", h_readdatavalid, 1'b0);
        chkb("reset h_stall_ack", h_stall_ack, 1'b0);
        chkb("reset wr_error", wr_error, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fr, hr, hw;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        x_fwait, x_hwait, x_cs, x_we;
    } vec_t;

    vec_t vecs [7];
    int   hgrants;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
        vecs[0] = '{1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 10'h020, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 10'h021, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 10'h022, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 10'h323, 4'hF, 32'h11112222, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 10'h323, 4'hF, 32'h11112222, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 10'h323, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};

        do_reset();

        // Single fetch read of the known word
        f_read = 1'b1; f_address = 10'h010;
        cycle();
        chkb("t1 f_waitrequest", s_fwait, 1'b0);
        chkb("t1 f_readdatavalid", s_fv, 1'b1);
        chk("t1 f_readdata", s_fd, 32'hDEADBEEF);
        chkb("t1 h_readdatavalid", s_hv, 1'b0);
        f_read = 1'b0;
        cycle();
        chkb("t1 valid one cycle", s_fv, 1'b0);

        for (int i = 0; i < 7; i++) begin
            f_read = vecs[i].fr; f_address = vecs[i].addr;
            h_read = vecs[i].hr; h_write = vecs[i].hw; h_address = vecs[i].addr;
            h_byteenable = vecs[i].be; h_writedata = vecs[i].wd;
            cycle();
            chkb($sformatf("vec%0d f_wait", i), s_fwait, vecs[i].x_fwait);
            chkb($sformatf("vec%0d h_wait", i), s_hwait, vecs[i].x_hwait);
            chkb($sformatf("vec%0d cs", i), s_cs, vecs[i].x_cs);
            chkb($sformatf("vec%0d we", i), s_we, vecs[i].x_we);
        end
        chk("vec readback", s_hd, 32'h11112222);
        idle_inputs();

        // Continuous contention: host wins every 9th cycle
        do_reset();
        f_read = 1'b1; f_address = 10'h040; h_read = 1'b1; h_address = 10'h100;
        hgrants = 0;
        for (int i = 0; i < 27; i++) begin
            cycle();
            chkb($sformatf("contest%0d h_wait", i), s_hwait, (i % 9) != 8);
            if (!s_hwait) hgrants++;
        end
        chk("contest host grants", 32'(hgrants), 32'd3);
        idle_inputs();

        // Partial host write then readback
        h_write = 1'b1; h_address = 10'h300; h_byteenable = 4'b0011; h_writedata = 32'h12345678;
        cycle();
        chkb("wr mem_write", s_we, 1'b1);
        h_write = 1'b0;
        cycle();
        chkb("wr mem_write once", s_we, 1'b0);
        h_read = 1'b1;
        cycle();
        chkb("wr readback valid", s_hv, 1'b1);
        chk("wr readback data", s_hd, 32'hCAFE5678);
        idle_inputs();

`ifdef IMEM_ARB_WRITE_PROT_EN
        h_write = 1'b1; h_address = 10'h020; h_byteenable = 4'hF; h_writedata = 32'h0BADF00D;
        cycle();
        chkb("prot shared h_wait", s_hwait, 1'b0);
        chkb("prot shared mem_write", s_we, 1'b0);
        chkb("prot shared wr_error", s_werr, 1'b1);
        h_write = 1'b0;
        cycle();
        chkb("prot wr_error pulse", s_werr, 1'b0);
`endif

        // Stall handshake with a fetch read still returning
        f_read = 1'b1; f_address = 10'h010;
        cycle();
        chkb("stall fetch granted", s_fwait, 1'b0);
        chkb("stall pending valid", s_fv, 1'b1);
        chk("stall pending data", s_fd, 32'hDEADBEEF);
        f_read = 1'b0; h_stall_req = 1'b1;
        cycle();
        chkb("stall ack in drain", s_ack, 1'b0);
        f_read = 1'b1; f_address = 10'h011;
        cycle();
        chkb("stall drain f_wait", s_fwait, 1'b1);
        chkb("stall ack", s_ack, 1'b1);
        h_write = 1'b1; h_address = 10'h020; h_byteenable = 4'hF; h_writedata = 32'h55AA55AA;
        cycle();
        chkb("excl host write", s_we, 1'b1);
        chkb("excl wr_error", s_werr, 1'b0);
        h_write = 1'b0;
        repeat (2) begin
            cycle();
            chkb("excl f_wait held", s_fwait, 1'b1);
        end
        h_stall_req = 1'b0;
        cycle();
        chkb("release ack falls", s_ack, 1'b0);
        cycle();
        chkb("release fetch granted", s_fwait, 1'b0);
        idle_inputs();

        // Reset during a host read grant
        h_stall_req = 1'b1;
        repeat (3) cycle();
        h_read = 1'b1; h_address = 10'h010;
        #1;
        chkb("rst h_wait", h_waitrequest, 1'b0);
        #1;
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chkb("rst async ack", h_stall_ack, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chkb("rst h_readdatavalid", h_readdatavalid, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chkb("post-rst h_readdatavalid", h_readdatavalid, 1'b0);
        f_read = 1'b1; h_read = 1'b1; h_address = 10'h100;
        for (int i = 0; i < 9; i++) begin
            cycle();
            chkb($sformatf("post-rst contest%0d h_wait", i), s_hwait, i != 8);
        end
        idle_inputs();

        // Random traffic; masters hold a request until it is accepted
        for (int n = 0; n < 3000; n++) begin
            if (!(f_read && s_fwait)) begin
                f_read = ($urandom % 4) != 0;
                f_address = 10'($urandom);
            end
            if (!((h_read || h_write) && s_hwait)) begin
                int op;
                op = int'($urandom % 3);
                h_read = (op == 1); h_write = (op == 2);
                h_address = 10'($urandom); h_byteenable = 4'($urandom);
                h_writedata = $urandom;
            end
            if ($urandom % 50 == 0) h_stall_req = !h_stall_req;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
- Shares the 1024x32 single-port on-chip instruction RAM between the CPU instruction-fetch master (read-only) and a host/debug master (read/write, used for program load and inspection).
- Drives the RAM's Avalon slave signals.
- Arbitrates per cycle with a bounded fetch priority.
- Provides a stall/acknowledge handshake so the host can take exclusive ownership for reloading code.

Parameters:
ADDR_W, 10, word address width (RAM depth 2^ADDR_W)
DATA_W, 32, data width
MAX_FETCH_RUN, 8, consecutive contested fetch wins before the host is forced a grant (range 1..255)
PROT_TOP, 256, addresses [0, PROT_TOP) are write-protected outside exclusive mode (optional feature only)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
f_read  in  1  fetch read request
f_address  in  ADDR_W  fetch word address
f_waitrequest  out  1  fetch request not accepted this cycle
f_readdata  out  DATA_W  fetch read data
f_readdatavalid  out  1  f_readdata valid
h_read  in  1  host read request
h_write  in  1  host write request (h_read and h_write never both high)
h_address  in  ADDR_W  host word address
h_byteenable  in  4  host byte enables
h_writedata  in  DATA_W  host write data
h_waitrequest  out  1  host request not accepted this cycle
h_readdata  out  DATA_W  host read data
h_readdatavalid  out  1  h_readdata valid
h_stall_req  in  1  host requests exclusive ownership (level)
h_stall_ack  out  1  exclusive ownership granted (level)
mem_address  out  ADDR_W  RAM address
mem_byteenable  out  4  RAM byte enables
mem_chipselect  out  1  RAM chipselect
mem_write  out  1  RAM write
mem_writedata  out  DATA_W  RAM write data
mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after address
mem_clken  out  1  RAM clock enable, tied 1
wr_error  out  1  protected-write drop pulse (optional feature)

Behaviour:
- Reset (reset_n low, async):
  - State SHARED; run counter 0.
  - h_stall_ack, f_readdatavalid, h_readdatavalid and wr_error all 0.
  - In-flight reads are discarded; no valid is issued after reset.
- States:
  - SHARED: both masters arbitrate.
  - DRAIN: h_stall_req seen; fetch is blocked; waiting for fetch reads to retire.
  - EXCLUSIVE: host only; h_stall_ack = 1.
- Transitions:
  - SHARED -> DRAIN when h_stall_req = 1.
  - DRAIN -> EXCLUSIVE when no fetch read is in flight, i.e. f_readdatavalid will not assert next cycle.
  - DRAIN -> SHARED when h_stall_req drops before ack.
  - EXCLUSIVE -> SHARED on the edge after h_stall_req = 0. h_stall_ack falls on that same edge.
- Grant (combinational from inputs, state and counter; at most one grant per cycle):
  - Only one requester: it is granted. Fetch is never granted in DRAIN or EXCLUSIVE.
  - Both request in SHARED: fetch wins if counter < MAX_FETCH_RUN; otherwise host wins.
  - Counter increments on each contested fetch win and clears on any host grant. It saturates; it never wraps.
- Handshake:
  - x_waitrequest = request & ~grant.
  - A request is consumed on the cycle its waitrequest is low. The master holds its signals until then.
- Memory drive:
  - Granted request drives mem_address and mem_chipselect = 1.
  - mem_write = granted host write; mem_byteenable = h_byteenable for host, 4'hF for fetch.
  - No grant: mem_chipselect = 0, mem_write = 0.
- Read return:
  - Latency is fixed at 1 cycle.
  - x_readdatavalid is registered (grant & read) for that master.
  - f_readdata = h_readdata = mem_readdata (shared bus, qualified by valid).
- Writes produce no valid.
- Back-to-back grants are allowed every cycle; full throughput is 1 access per clock.

Optional Feature:
IMEM_ARB_WRITE_PROT_EN
- Defined:
  - A host write with h_address < PROT_TOP while the state is not EXCLUSIVE is accepted (waitrequest low) but dropped: mem_chipselect = 0, mem_write = 0.
  - wr_error pulses high for 1 cycle on the following clock.
  - In EXCLUSIVE, all writes pass.
- Undefined: all host writes pass in every state; wr_error is tied 0; PROT_TOP is unused.

Test Plan:
- Reset then single fetch read at address 0x010, RAM word 0xDEADBEEF -> f_waitrequest 0, f_readdatavalid high exactly 1 cycle later with 0xDEADBEEF; h_readdatavalid stays 0.
- Fetch and host read continuously contested, MAX_FETCH_RUN = 8 -> 8 fetch grants, 1 host grant, repeating; h_waitrequest low exactly every 9th cycle.
- Host write 0x12345678 with byteenable 4'b0011 to 0x300, then read back -> mem_write 1 for 1 cycle; readback 0x????5678 (upper half unchanged).
- Fetch read granted, then h_stall_req asserted next cycle -> DRAIN, pending f_readdatavalid delivered, then h_stall_ack = 1; subsequent f_read held with f_waitrequest = 1 until h_stall_req = 0.
- With IMEM_ARB_WRITE_PROT_EN, host write to 0x020 in SHARED -> no mem_write, wr_error pulses 1 cycle. Same write in EXCLUSIVE -> mem_write 1, wr_error 0.
- Assert reset_n low the cycle after a host read grant -> h_readdatavalid never asserts; state SHARED and counter 0 after release.
